// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   8N1 UART transmitter, LSB first, fed by a small byte FIFO. The baud rate
//   is chosen at runtime through iRate. The rate codes match the receiver's
//   oRate encoding. The rate is latched when each frame starts, so changing
//   iRate mid-frame only affects later frames.
//
// Ports
//   clk     in   1             system clock, rising edge
//   reset   in   1             synchronous, active-high reset
//   iRate   in   2             00=9600, 01=19200, 10=57600, 11=115200
//   iData   in   8             byte to transmit
//   iValid  in   1             iData valid; accepted when iValid && oReady
//   oReady  out  1             FIFO not full (forced low during reset)
//   TX      out  1             registered serial line, idles high
//   oBusy   out  1             frame on the line or FIFO non-empty
//   oCount  out  clog2(D)+1    FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    iRate,
    input  logic [7:0]                    iData,
    input  logic                          iValid,
    output logic                          oReady,
    output logic                          TX,
    output logic                          oBusy,
    output logic [$clog2(FIFO_DEPTH):0]   oCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    // Bit periods in clock cycles. Integer division truncates.
    localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / 9600);
    localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / 19200);
    localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / 57600);
    localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / 115200);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

    function automatic logic [15:0] rateDiv(input logic [1:0] rate);
        case (rate)
            2'b00:   return DIV_9600;
            2'b01:   return DIV_19200;
            2'b10:   return DIV_57600;
            default: return DIV_115200;
        endcase
    endfunction

    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count;
    logic             push, pop, notEmpty;

    stateType         state, nextState;
    logic [15:0]      bitCnt, divReg;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             bitDone, txNext;

    assign notEmpty = (count != '0);
    assign oReady   = !reset && (count != FULL_COUNT);
    assign push     = iValid && oReady;
    assign bitDone  = (bitCnt == divReg - 16'd1);
    assign oBusy    = (state != IDLE) || notEmpty;
    assign oCount   = count;

    // ---------------- FIFO ----------------
    // NOTE: the storage array has no reset; the pointers and the count define
    // which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push)
            fifoMem[wrPtr] <= iData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;   // idle, or push and pop together
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked block uses non-blocking assignments, so all
    // registers update together from values taken before the edge.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (notEmpty) nextState = START;
            START: if (bitDone)  nextState = DATA;
            DATA:  if (bitDone && bitIdx == 3'd7) nextState = STOP;
            STOP:  if (bitDone)  nextState = notEmpty ? START : IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // NOTE: outputs get defaults before the case, so no path leaves them
    // unassigned and no latch is inferred.
    always_comb begin
        txNext = 1'b1;
        pop    = 1'b0;
        unique case (state)
            IDLE:  pop    = notEmpty;
            START: txNext = 1'b0;
            DATA:  txNext = shiftReg[0];
            STOP:  pop    = bitDone && notEmpty;   // back-to-back frame, no gap
        endcase
    end

    // ---------------- Bit timing / shift datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            divReg   <= DIV_115200;
        end else if (pop) begin
            // Starting a frame: load the byte and latch the rate for the whole frame.
            shiftReg <= fifoMem[rdPtr];
            divReg   <= rateDiv(iRate);
            bitCnt   <= '0;
            bitIdx   <= '0;
        end else if (state != IDLE) begin
            if (bitDone) begin
                bitCnt <= '0;
                if (state == DATA) begin
                    shiftReg <= {1'b0, shiftReg[7:1]};
                    bitIdx   <= bitIdx + 1'b1;
                end
            end else begin
                bitCnt <= bitCnt + 16'd1;
            end
        end
    end

    // TX follows the current state one cycle later, so the line is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) TX <= 1'b1;
        else       TX <= txNext;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    // Main DUT runs at 1.152 MHz so every rate divides exactly:
    // bit lengths of 120 / 60 / 20 / 10 cycles.
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] iRate;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady, TX, oBusy;
    logic [2:0] oCount;

    // Second DUT with the default 100 MHz clock, used to check the real divisors.
    logic [1:0] rate2;
    logic [7:0] data2;
    logic       valid2;
    logic       ready2, tx2, busy2;
    logic [2:0] count2;

    uart_tx_fifo #(.CLK_FREQ(1_152_000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .iRate(iRate), .iData(iData), .iValid(iValid),
        .oReady(oReady), .TX(TX), .oBusy(oBusy), .oCount(oCount)
    );

    uart_tx_fifo dut100 (
        .clk(clk), .reset(reset), .iRate(rate2), .iData(data2), .iValid(valid2),
        .oReady(ready2), .TX(tx2), .oBusy(busy2), .oCount(count2)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic txOf(input int which);
        return (which == 1) ? tx2 : TX;
    endfunction

    // Wait up to idleMax cycles for a start bit, then compare every cycle of a
    // 10*div frame against the ideal 8N1 waveform for byte b.
    task automatic expectFrame(input int which, input logic [7:0] b, input int div,
                               input int idleMax, input string name);
        int       waited = 0;
        int       bad    = 0;
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        while (txOf(which) !== 1'b0 && waited < idleMax) begin
            @(negedge clk);
            waited++;
        end
        check({name, ".start"}, txOf(which), 1'b0);
        for (int k = 0; k < 10 * div; k++) begin
            if (txOf(which) !== frame[k / div]) bad++;
            @(negedge clk);
        end
        check({name, ".badCycles"}, bad, 0);
    endtask

    typedef struct {
        logic [1:0] rate;
        logic [7:0] data;
        int         div;
        string      name;
    } vecT;

    vecT        vecs [6];
    logic [7:0] t2Bytes [4];
    logic [7:0] t3Bytes [5];
    logic [7:0] t6Bytes [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  i, held, guard, maxCnt, bad;
        logic acc, sawFull, readyAtFull;

        vecs[0] = '{2'b00, 8'h34, 120, "v9600"};
        vecs[1] = '{2'b01, 8'h4D,  60, "v19200"};
        vecs[2] = '{2'b10, 8'h35,  20, "v57600"};
        vecs[3] = '{2'b11, 8'h62,  10, "v115200"};
        vecs[4] = '{2'b11, 8'h00,  10, "vZeros"};
        vecs[5] = '{2'b11, 8'hFF,  10, "vOnes"};
        t2Bytes = '{8'h4D, 8'h35, 8'h62, 8'h34};
        t3Bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        t6Bytes = '{8'h34, 8'h4D, 8'h3F};

        reset = 1'b1; iRate = 2'b00; iData = 8'h00; iValid = 1'b0;
        rate2 = 2'b11; data2 = 8'h00; valid2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.oReady", oReady, 1'b0);
        check("rst.TX",     TX,     1'b1);
        check("rst.oBusy",  oBusy,  1'b0);
        check("rst.oCount", oCount, 3'd0);
        check("rst.tx2",    tx2,    1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("rel.oReady", oReady, 1'b1);
        check("rel.TX",     TX,     1'b1);

        // Table: single byte at each rate, latency and exact frame shape
        for (int v = 0; v < 6; v++) begin
            iRate = vecs[v].rate; iData = vecs[v].data; iValid = 1'b1;
            @(negedge clk);                              // accepted at edge N
            iValid = 1'b0;
            check({vecs[v].name, ".countAfterPush"}, oCount, 3'd1);
            check({vecs[v].name, ".idleBeforePop"},  TX, 1'b1);
            @(negedge clk);                              // popped at edge N+1
            check({vecs[v].name, ".countAfterPop"},  oCount, 3'd0);
            check({vecs[v].name, ".busyAfterPop"},   oBusy, 1'b1);
            check({vecs[v].name, ".txHighAtPop"},    TX, 1'b1);
            @(negedge clk);                              // TX falls at edge N+2
            expectFrame(0, vecs[v].data, vecs[v].div, 0, vecs[v].name);
            check({vecs[v].name, ".busyAfterFrame"}, oBusy, 1'b0);
            check({vecs[v].name, ".txIdleAfter"},    TX, 1'b1);
        end

        // T2: four consecutive pushes, back-to-back frames
        iRate = 2'b11;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    check("t2.oReady", oReady, 1'b1);
                    iData = t2Bytes[k]; iValid = 1'b1;
                    @(negedge clk);
                end
                iValid = 1'b0;
            end
            begin
                expectFrame(0, t2Bytes[0], 10, 10, "t2.f0");
                for (int k = 1; k < 4; k++) expectFrame(0, t2Bytes[k], 10, 0, "t2.fN");
            end
        join
        check("t2.busyEnd",  oBusy,  1'b0);
        check("t2.countEnd", oCount, 3'd0);

        // T3: fill the FIFO while a frame is in flight, fifth byte must wait
        iRate = 2'b11;
        fork
            begin
                iData = 8'hC3; iValid = 1'b1;
                @(negedge clk);
                iValid = 1'b0;
                repeat (2) @(negedge clk);
                i = 0; held = 0; guard = 0; maxCnt = 0; sawFull = 1'b0; readyAtFull = 1'b1;
                while (i < 5 && guard < 400) begin
                    iData = t3Bytes[i]; iValid = 1'b1;
                    if (oCount == 3'd4 && !sawFull) begin
                        sawFull = 1'b1;
                        readyAtFull = oReady;
                    end
                    acc = oReady;
                    if (!acc) held++;
                    @(negedge clk);
                    guard++;
                    if (acc) i++;
                    if (int'(oCount) > maxCnt) maxCnt = int'(oCount);
                end
                iValid = 1'b0;
                check("t3.allPushed",  i, 5);
                check("t3.maxCount",   maxCnt, 4);
                check("t3.readyFull",  readyAtFull, 1'b0);
                check("t3.fifthHeld",  held > 0, 1'b1);
            end
            begin
                expectFrame(0, 8'hC3, 10, 10, "t3.f0");
                for (int k = 0; k < 5; k++) expectFrame(0, t3Bytes[k], 10, 0, "t3.fN");
            end
        join
        bad = 0;
        repeat (30) begin
            if (TX !== 1'b1 || oBusy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("t3.noExtraFrame", bad, 0);

        // T4: rate switched mid-frame only affects the next frame
        iRate = 2'b00;
        fork
            begin
                iData = 8'hA7; iValid = 1'b1;
                @(negedge clk);
                iData = 8'h5C;
                @(negedge clk);
                iValid = 1'b0;
                check("t4.pushPopCount", oCount, 3'd1);
                repeat (300) @(negedge clk);
                iRate = 2'b11;
            end
            begin
                expectFrame(0, 8'hA7, 120, 10, "t4.slow");
                expectFrame(0, 8'h5C,  10,  0, "t4.fast");
            end
        join

        // T5: reset during data bit 3 with two bytes queued
        iRate = 2'b10;
        for (int k = 0; k < 3; k++) begin
            iData = (k == 0) ? 8'hF7 : 8'h81; iValid = 1'b1;
            @(negedge clk);
        end
        iValid = 1'b0;
        repeat (90) @(negedge clk);                      // middle of bit 3 (value 0)
        check("t5.queued",  oCount, 3'd2);
        check("t5.inBit3",  TX, 1'b0);
        reset = 1'b1; iValid = 1'b1; iData = 8'hEE;
        @(negedge clk);
        check("t5.txHigh",   TX,     1'b1);
        check("t5.count0",   oCount, 3'd0);
        check("t5.busy0",    oBusy,  1'b0);
        check("t5.readyLow", oReady, 1'b0);
        reset = 1'b0; iValid = 1'b0;
        @(negedge clk);
        check("t5.readyHigh", oReady, 1'b1);
        bad = 0;
        repeat (200) begin
            if (TX !== 1'b1 || oBusy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("t5.quiet", bad, 0);
        iData = 8'h3C; iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        expectFrame(0, 8'h3C, 20, 5, "t5.after");

        // T6: three bytes at 9600, in order, back-to-back
        iRate = 2'b00;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    iData = t6Bytes[k]; iValid = 1'b1;
                    @(negedge clk);
                end
                iValid = 1'b0;
            end
            begin
                expectFrame(0, t6Bytes[0], 120, 10, "t6.f0");
                for (int k = 1; k < 3; k++) expectFrame(0, t6Bytes[k], 120, 0, "t6.fN");
            end
        join

        // 100 MHz divisors: 868 at 115200 and truncated 1736 at 57600
        rate2 = 2'b11; data2 = 8'h5A; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        expectFrame(1, 8'h5A, 868, 5, "d100.115200");
        rate2 = 2'b10; data2 = 8'hA6; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        expectFrame(1, 8'hA6, 1736, 5, "d100.57600");
        check("d100.busyEnd", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
